// File: rtl/mul8_apx_seq_ctrl.sv
// Sequenced 8x8 approximate multiplier sharing one ap1 and one ap3 4x4 unit.
// Define ZERO_SKIP_EN to short-circuit zero operands straight to DONE.

module mul4_ap1 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  // exact array product minus the x[0]&y[0] partial product
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if ((i + j) != 0)
          p = p + (8'(x[i] & y[j]) << (i + j));
  end
endmodule

module mul4_ap3 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  // drops all partial products of weight 1 and 2
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if ((i + j) >= 2)
          p = p + (8'(x[i] & y[j]) << (i + j));
  end
endmodule

module mul8_apx_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      prod8,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    PH0,
    PH1,
    DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]  ra, rb;
  logic [15:0] acc;
  logic [3:0]  ymux;
  logic [7:0]  p1, p3;
  logic        load;
  logic        handoff;

  assign ymux = (state == PH0) ? rb[7:4] : rb[3:0];

  mul4_ap1 u_ap1 (
    .x (ra[7:4]),
    .y (ymux),
    .p (p1)
  );

  mul4_ap3 u_ap3 (
    .x (ra[3:0]),
    .y (ymux),
    .p (p3)
  );

  assign busy    = (state != IDLE);
  assign handoff = out_valid & out_ready;

`ifdef ZERO_SKIP_EN
  logic zero_op;
  logic skip;
  assign zero_op = (a == 8'h00) || (b == 8'h00);
  assign skip    = load & zero_op;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_n = PH0;
        end
      end
      PH0: state_n = PH1;
      PH1: state_n = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_n = PH0;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
`ifdef ZERO_SKIP_EN
    if (load && zero_op) state_n = DONE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra        <= '0;
      rb        <= '0;
      acc       <= '0;
      prod8     <= '0;
      out_valid <= 1'b0;
      ops_done  <= '0;
    end else begin
      if (load) begin
        ra <= a;
        rb <= b;
      end
      if (state == PH0)
        acc <= {p1, 8'h00} + {4'h0, p3, 4'h0};
      if (state == PH1) begin
        prod8     <= acc + {4'h0, p1, 4'h0} + {8'h00, p3};
        out_valid <= 1'b1;
      end
      if (handoff) begin
        out_valid <= 1'b0;
        if (ops_done != '1)
          ops_done <= ops_done + 1'b1;
      end
`ifdef ZERO_SKIP_EN
      if (skip) begin
        prod8     <= '0;
        out_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mul8_apx_seq_ctrl.sv
// Self-checking bench for mul8_apx_seq_ctrl against an arithmetic model.
// Honours ZERO_SKIP_EN when compiled with it.

module tb_mul8_apx_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod8;
  logic        busy;
  logic [15:0] ops_done;

  int checks   = 0;
  int failures = 0;
  int exp_ops  = 0;

  always #5 clk = ~clk;

  mul8_apx_seq_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod8     (prod8),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  // ap1: exact product less the lsb partial product
  function automatic int ap1_m(input int x, input int y);
    return x * y - ((x & 1) * (y & 1));
  endfunction

  // ap3: exact product less everything below weight 4
  function automatic int ap3_m(input int x, input int y);
    int lo;
    lo = (x & 1) * (y & 1) + 2 * ((x & 1) * ((y >> 1) & 1))
       + 2 * (((x >> 1) & 1) * (y & 1));
    return x * y - lo;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] x,
                                           input logic [7:0] y);
    int ah, al, bh, bl, s;
    ah = int'(x[7:4]); al = int'(x[3:0]);
    bh = int'(y[7:4]); bl = int'(y[3:0]);
    s = ap1_m(ah, bh) * 256 + (ap3_m(al, bh) + ap1_m(ah, bl)) * 16
      + ap3_m(al, bl);
    return 16'(s);
  endfunction

  function automatic int lat_of(input logic [7:0] x, input logic [7:0] y);
`ifdef ZERO_SKIP_EN
    if (x == 8'h00 || y == 8'h00) return 1;
`endif
    return 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string nm, input logic [7:0] x,
                       input logic [7:0] y);
    logic [15:0] e;
    int lat, n;
    bit seen;
    e = ref_prod(x, y);
    lat = lat_of(x, y);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready got=%b want=1", nm, in_ready);
    end
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
      end
      if (out_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != lat) begin
      failures++;
      $display("FAIL %s latency got=%0d seen=%0d want=%0d", nm, n, seen, lat);
    end
    checks++;
    if (prod8 !== e) begin
      failures++;
      $display("FAIL %s prod8 got=%h want=%h", nm, prod8, e);
    end
    tick();
    exp_ops++;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s out_valid_drop got=%b want=0", nm, out_valid);
    end
    checks++;
    if (ops_done !== 16'(exp_ops)) begin
      failures++;
      $display("FAIL %s ops_done got=%0d want=%0d", nm, ops_done, exp_ops);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    exp_ops = 0;
    checks += 5;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid);
    end
    if (prod8 !== 16'h0000) begin
      failures++; $display("FAIL rst_prod8 got=%h want=0000", prod8);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy got=%b want=0", busy);
    end
    if (ops_done !== 16'd0) begin
      failures++; $display("FAIL rst_ops_done got=%0d want=0", ops_done);
    end
  endtask

  task automatic test_single();
    do_op("single", 8'hA7, 8'h3C);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL single_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] x, y, x2, y2;
    logic [15:0] e;
    int n;
    x = 8'($urandom_range(1, 255)); y = 8'($urandom_range(1, 255));
    x2 = 8'($urandom_range(1, 255)); y2 = 8'($urandom_range(1, 255));
    e = ref_prod(x, y);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      tick(); n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_wait got=%b want=1", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      tick();
      checks += 3;
      if (prod8 !== e) begin
        failures++; $display("FAIL bp_hold prod8 got=%h want=%h", prod8, e);
      end
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready);
      end
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_out_valid got=%b want=1", out_valid);
      end
    end
    a = x2; b = y2; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release in_ready got=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    exp_ops++;
    checks += 3;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_handoff out_valid got=%b want=0", out_valid);
    end
    if (ops_done !== 16'(exp_ops)) begin
      failures++; $display("FAIL bp_ops got=%0d want=%0d", ops_done, exp_ops);
    end
    if (busy !== 1'b1) begin
      failures++; $display("FAIL bp_reaccept busy got=%b want=1", busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_early got=%b want=0", out_valid);
    end
    tick();
    checks += 2;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_next got=%b want=1", out_valid);
    end
    if (prod8 !== ref_prod(x2, y2)) begin
      failures++;
      $display("FAIL bp_next prod8 got=%h want=%h", prod8, ref_prod(x2, y2));
    end
    tick();
    exp_ops++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] e;
    logic [7:0] x, y;
    int sent, got, last, cyc;
    sent = 0; got = 0; last = -1;
    x = 8'($urandom_range(1, 255)); y = 8'($urandom_range(1, 255));
    out_ready = 1'b1;
    for (cyc = 0; cyc < 400 && got < 100; cyc++) begin
      in_valid = (sent < 100);
      a = x; b = y;
      #1;
      if (out_valid === 1'b1) begin
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        checks++;
        if (prod8 !== e) begin
          failures++;
          $display("FAIL b2b prod8 #%0d got=%h want=%h", got, prod8, e);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            failures++;
            $display("FAIL b2b spacing got=%0d want=3", cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(ref_prod(x, y));
        sent++;
        x = 8'($urandom_range(1, 255)); y = 8'($urandom_range(1, 255));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    exp_ops += 100;
    checks += 2;
    if (got != 100) begin
      failures++; $display("FAIL b2b count got=%0d want=100", got);
    end
    if (ops_done !== 16'(exp_ops)) begin
      failures++; $display("FAIL b2b ops_done got=%0d want=%0d", ops_done, exp_ops);
    end
    tick(); tick();
  endtask

  task automatic test_reset_midop();
    int bad;
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    exp_ops = 0;
    checks += 4;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst out_valid got=%b want=0", out_valid);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL midrst busy got=%b want=0", busy);
    end
    if (prod8 !== 16'h0000) begin
      failures++; $display("FAIL midrst prod8 got=%h want=0000", prod8);
    end
    if (ops_done !== 16'd0) begin
      failures++; $display("FAIL midrst ops_done got=%0d want=0", ops_done);
    end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL midrst quiet got=%0d want=0", bad);
    end
    do_op("after_rst", 8'hFF, 8'hFF);
  endtask

  task automatic test_zero();
    do_op("zero_a", 8'h00, 8'h5A);
    do_op("zero_b", 8'h33, 8'h00);
    do_op("nz_min", 8'h01, 8'h01);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
